// File: rtl/video_raster_gen.sv
// Raster timing generator with a one-cycle-ahead pixel fetch, a registered video
// output, a sticky underrun flag and a character clock. TEST_PATTERN_EN adds a border/diagonal test pattern.
module video_raster_gen #(
  parameter int H_ACTIVE = 512,
  parameter int H_BLANK  = 128,
  parameter int V_ACTIVE = 240,
  parameter int V_BLANK  = 16,
  parameter int V_SWITCH = 8,
  parameter int N_FIELDS = 2,
  parameter int CHAR_W   = 8
) (
  input  logic                        clk_pixel,
  input  logic                        rst_n,
`ifdef TEST_PATTERN_EN
  input  logic                        pattern_en,
`endif
  output logic                        pix_req,
  output logic [$clog2(H_ACTIVE)-1:0] pix_x,
  output logic [$clog2(V_ACTIVE)-1:0] pix_y,
  input  logic                        pix_valid,
  input  logic                        pix_data,
  input  logic                        underrun_clr,
  output logic                        hdrive,
  output logic [$clog2(N_FIELDS)-1:0] field,
  output logic                        video,
  output logic                        clk_char_out,
  output logic                        underrun
);

  localparam int HT  = H_BLANK + H_ACTIVE;
  localparam int VT  = V_BLANK + V_ACTIVE;
  localparam int HCW = $clog2(HT);
  localparam int VCW = $clog2(VT);
  localparam int XW  = $clog2(H_ACTIVE);
  localparam int YW  = $clog2(V_ACTIVE);
  localparam int FW  = $clog2(N_FIELDS);
  localparam int CW  = $clog2(CHAR_W);

  localparam logic [HCW-1:0] H_LAST   = HCW'(HT - 1);
  localparam logic [HCW-1:0] H_BL     = HCW'(H_BLANK);
  localparam logic [HCW-1:0] H_REQ_LO = HCW'(H_BLANK - 1);
  localparam logic [HCW-1:0] H_REQ_HI = HCW'(HT - 2);
  localparam logic [VCW-1:0] V_LAST   = VCW'(VT - 1);
  localparam logic [VCW-1:0] V_BL     = VCW'(V_BLANK);
  localparam logic [VCW-1:0] V_SW     = VCW'(V_SWITCH);
  localparam logic [FW-1:0]  F_LAST   = FW'(N_FIELDS - 1);

  logic [HCW-1:0] hcount_q, hcount_d;
  logic [VCW-1:0] vcount_q, vcount_d;
  logic [FW-1:0]  field_q, field_d;
  logic [CW-1:0]  char_q, char_d;
  logic           video_q, video_d;
  logic           hdrive_q, hdrive_d;
  logic           underrun_q, underrun_d;
  logic           h_wrap, hblank, vblank, active, pix_bit, set_underrun;

`ifdef TEST_PATTERN_EN
  localparam logic [XW-1:0] X_HI = XW'(H_ACTIVE - 3);
  localparam logic [YW-1:0] Y_HI = YW'(V_ACTIVE - 3);
  logic [XW-1:0] pat_x;
  logic [YW-1:0] pat_y;
  logic          border, diag;
`endif

  always_comb begin
    h_wrap   = (hcount_q == H_LAST);
    hcount_d = h_wrap ? '0 : hcount_q + 1'b1;
    vcount_d = vcount_q;
    field_d  = field_q;
    if (h_wrap) begin
      vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
      if (vcount_d == V_SW) field_d = (field_q == F_LAST) ? '0 : field_q + 1'b1;
    end
    char_d = char_q + 1'b1;

    hblank = (hcount_q < H_BL);
    vblank = (vcount_q < V_BL);
    active = !hblank && !vblank;

    // The fetch runs one pixel ahead, so it never spills into the next line.
    pix_req = !vblank && (hcount_q >= H_REQ_LO) && (hcount_q <= H_REQ_HI);
    pix_x   = pix_req ? XW'(hcount_q - H_REQ_LO) : '0;
    pix_y   = pix_req ? YW'(vcount_q - V_BL) : '0;

    pix_bit      = pix_valid && pix_data;
    set_underrun = active && !pix_valid;
`ifdef TEST_PATTERN_EN
    pat_x  = XW'(hcount_q - H_BL);
    pat_y  = YW'(vcount_q - V_BL);
    border = (pat_y < YW'(2)) || (pat_y > Y_HI) || (pat_x < XW'(2)) || (pat_x > X_HI);
    diag   = field_q[0] ? (pat_x[1:0] == ~pat_y[1:0]) : (pat_x[1:0] == pat_y[1:0]);
    if (pattern_en) begin
      pix_bit      = border || diag;
      set_underrun = 1'b0;
    end
`endif

    video_d    = active && pix_bit;
    hdrive_d   = !hblank;
    underrun_d = set_underrun ? 1'b1 : (underrun_clr ? 1'b0 : underrun_q);
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      hcount_q   <= '0;
      vcount_q   <= '0;
      field_q    <= '0;
      char_q     <= '0;
      video_q    <= 1'b0;
      hdrive_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      hcount_q   <= hcount_d;
      vcount_q   <= vcount_d;
      field_q    <= field_d;
      char_q     <= char_d;
      video_q    <= video_d;
      hdrive_q   <= hdrive_d;
      underrun_q <= underrun_d;
    end
  end

  assign hdrive       = hdrive_q;
  assign field        = field_q;
  assign video        = video_q;
  assign underrun     = underrun_q;
  assign clk_char_out = ~char_q[CW-1];

endmodule
